// File: rtl/state_trace_fifo_pkg.sv
// Shared constants and types for the state-trace FIFO: snapshot layout and
// the bit positions of each field inside a trace entry.
package state_trace_fifo_pkg;

    // Snapshot = {sta, z1, z2}
    localparam int unsigned STA_W  = 3;
    localparam int unsigned Z1_W   = 2;
    localparam int unsigned Z2_W   = 2;
    localparam int unsigned SNAP_W = STA_W + Z1_W + Z2_W;  // 7

    // Entry = {delta, sta, z1, z2}, MSB first; delta sits above the snapshot
    localparam int unsigned Z2_LSB    = 0;
    localparam int unsigned Z1_LSB    = Z2_LSB + Z2_W;
    localparam int unsigned STA_LSB   = Z1_LSB + Z1_W;
    localparam int unsigned DELTA_LSB = SNAP_W;

    typedef struct packed {
        logic [STA_W-1:0] sta;
        logic [Z1_W-1:0]  z1;
        logic [Z2_W-1:0]  z2;
    } snap_t;

endpackage

// File: rtl/state_trace_fifo_mem.sv
// Trace storage: DEPTH x WIDTH register array, one synchronous write port
// and one asynchronous read port. Contents are not reset; the top masks the
// read data while the FIFO is empty.
module trace_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 15
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/state_trace_fifo.sv
// State-trace FIFO: records every change of the upstream {sta, z1, z2}
// snapshot together with the number of cycles since the previous change.
// First-word fall-through read side; sticky overflow on dropped events.
module state_trace_fifo
    import state_trace_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [STA_W-1:0]       i_sta,
    input  logic [Z1_W-1:0]        i_z1,
    input  logic [Z2_W-1:0]        i_z2,
    input  logic                   i_clr,
    input  logic                   i_rd_ready,
    output logic                   o_rd_valid,
    output logic [SNAP_W+TS_W-1:0] o_rd_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = SNAP_W + TS_W;
    localparam logic [TS_W-1:0] DELTA_MAX = '1;

    snap_t           live;
    snap_t           snap_q;
    logic [TS_W-1:0] delta_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            ovf_q;
    logic            event_hit;
    logic            full;
    logic            pop;
    logic            push;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   rdata;

    assign live      = '{sta: i_sta, z1: i_z1, z2: i_z2};
    assign event_hit = (live != snap_q);
    assign full      = (count_q == CW'(DEPTH));
    assign o_rd_valid = (count_q != '0);
    // A full FIFO still accepts an event when the head leaves in the same cycle
    assign pop       = o_rd_valid && i_rd_ready && !i_clr;
    assign push      = event_hit && (!full || pop) && !i_clr;

    assign o_count    = count_q;
    assign o_overflow = ovf_q;
    assign o_rd_data  = o_rd_valid ? rdata : '0;

    // Assemble the entry from the pre-reload delta and the live snapshot
    always_comb begin
        wdata = '0;
        wdata[DELTA_LSB +: TS_W] = delta_q;
        wdata[STA_LSB +: STA_W]  = live.sta;
        wdata[Z1_LSB +: Z1_W]    = live.z1;
        wdata[Z2_LSB +: Z2_W]    = live.z2;
    end

    // Snapshot register, updated every cycle (clear does not affect it)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= live;
        end
    end

    // Saturating delta counter; reloads to 1 after an event
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            delta_q <= '0;
        end else if (i_clr) begin
            delta_q <= '0;
        end else if (event_hit) begin
            delta_q <= TS_W'(1);
        end else if (delta_q != DELTA_MAX) begin
            delta_q <= delta_q + TS_W'(1);
        end
    end

    // Read/write pointers (wrap naturally at DEPTH) and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (i_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Sticky overflow: an event found the FIFO full with nothing leaving
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else if (i_clr) begin
            ovf_q <= 1'b0;
        end else if (event_hit && full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (i_clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: doc/state_trace_fifo.md
STATE_TRACE_FIFO -- requirements
Module: state_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of trace entries; power of two, at least 2.
REQ-002 Parameter TS_W, default 8: width of the delta-timestamp field.
REQ-003 i_clk  input  1: sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1: reset, asynchronous and active-low.
REQ-005 i_sta  input  3: state code from the upstream state machine.
REQ-006 i_z1  input  2: upstream output z1.
REQ-007 i_z2  input  2: upstream output z2.
REQ-008 i_clr  input  1: synchronous clear of the FIFO, the overflow flag and the timestamp counter.
REQ-009 i_rd_ready  input  1: the consumer accepts the head entry.
REQ-010 o_rd_valid  output  1: the FIFO holds at least one entry.
REQ-011 o_rd_data  output  7+TS_W: head entry {delta[TS_W-1:0], sta[2:0], z1[1:0], z2[1:0]}, MSB first; first-word fall-through.
REQ-012 o_count  output  log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-013 o_overflow  output  1: sticky flag; at least one event was dropped.

Function
REQ-014 The block SHALL register the snapshot {i_sta,i_z1,i_z2} every cycle; the registered value resets to 0.
REQ-015 An event SHALL occur in any cycle where the live snapshot differs from the registered snapshot.
REQ-016 The delta counter SHALL increment every cycle and saturate at 2^TS_W-1.
REQ-017 On an event, the counter SHALL reload to 1 in the next cycle; the entry records the pre-reload value.
REQ-018 On an event, the entry {delta, live sta, live z1, live z2} SHALL be written when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-019 An event finding the FIFO full with no simultaneous pop SHALL be dropped and SHALL set o_overflow.
REQ-020 o_overflow SHALL remain set until i_clr or reset.
REQ-021 A pop SHALL occur when o_rd_valid and i_rd_ready are both high; o_rd_data advances in the next cycle.
REQ-022 o_rd_valid SHALL equal (o_count!=0), with no combinational path from i_rd_ready.
REQ-023 A simultaneous push and pop SHALL leave o_count unchanged; a push into an empty FIFO is visible one cycle after the event.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 i_clr SHALL take priority over a same-cycle push and pop: count 0, overflow 0, delta counter 0, snapshot updated normally.
REQ-026 Timing: event in cycle N; entry visible on o_rd_data in cycle N+1 if it reaches the head.

Reset
REQ-027 While i_rst_n is low: o_rd_valid=0, o_count=0, o_overflow=0, pointers=0, delta counter=0, snapshot=0; o_rd_data SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately; no partial entry survives.
REQ-029 The first cycle after reset release SHALL compare the live snapshot against 0.

Structure
REQ-030 A shared package SHALL hold the entry field offsets and widths and the snapshot width constant (7).
REQ-031 Storage SHALL be a single sub-module trace_fifo_mem (DEPTH x (7+TS_W) register array, one write port, one async read port); pointer and control logic stay in the top.

Verification
REQ-032 Reset release with i_sta=0, z1=0, z2=0 held for 5 cycles -> o_rd_valid stays 0, o_count=0.
REQ-033 i_sta goes 0->1 at cycle 3 after reset, i_rd_ready=1 -> one entry with delta=3, sta=1, z1=0, z2=0.
REQ-034 No event for 300 cycles (TS_W=8), then an event -> delta=255 (saturated).
REQ-035 i_rd_ready=0; 10 distinct snapshots on consecutive cycles (DEPTH=8) -> o_count=8, o_overflow=1, entries 1..8 read in order, entries 9-10 absent.
REQ-036 FIFO full, an event plus i_rd_ready=1 in the same cycle -> o_count stays 8, o_overflow stays 0, the new entry appears last.
REQ-037 Assert i_clr with 4 entries, then pulse i_rst_n low for 3 ns with 2 entries -> o_count=0, o_overflow=0 in both cases, and o_rd_valid=0 in the next cycle.
